// File: rtl/mbinit_sb_tx_arbiter_if.sv
// Sideband TX arbitration bundle: two requesters, serializer feedback, error clear
// and the arbiter's grant/launch/status outputs.
interface mbinit_sb_tx_arbiter_if;
    logic       i_req_module;
    logic [3:0] i_msg_module;
    logic       i_req_partner;
    logic [3:0] i_msg_partner;
    logic       i_falling_edge_busy;
    logic       i_err_clr;
    logic       o_gnt_module;
    logic       o_gnt_partner;
    logic [3:0] o_TX_SbMessage;
    logic       o_ValidOutData;
    logic       o_busy;
    logic       o_timeout_err;

    // master is the arbiter itself; slave is the requester/serializer side
    modport master (
        input  i_req_module, i_msg_module, i_req_partner, i_msg_partner,
        input  i_falling_edge_busy, i_err_clr,
        output o_gnt_module, o_gnt_partner, o_TX_SbMessage, o_ValidOutData,
        output o_busy, o_timeout_err
    );

    modport slave (
        output i_req_module, i_msg_module, i_req_partner, i_msg_partner,
        output i_falling_edge_busy, i_err_clr,
        input  o_gnt_module, o_gnt_partner, o_TX_SbMessage, o_ValidOutData,
        input  o_busy, o_timeout_err
    );
endinterface

// File: rtl/mbinit_sb_tx_arbiter.sv
// Two-way round-robin arbiter for the MBINIT sideband TX channel: one message in
// flight at a time, with a watchdog on the serializer's completion pulse.
module mbinit_sb_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16'd8000,
    parameter int          CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    mbinit_sb_tx_arbiter_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        ERROR     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       msg_q, msg_d;
    logic             owner_partner_q, owner_partner_d;
    logic             last_partner_q, last_partner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             pick_partner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            msg_q           <= 4'b0000;
            owner_partner_q <= 1'b0;
            last_partner_q  <= 1'b0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            msg_q           <= msg_d;
            owner_partner_q <= owner_partner_d;
            last_partner_q  <= last_partner_d;
            cnt_q           <= cnt_d;
            err_q           <= err_d;
        end
    end

    // On a tie the side not granted last wins; a lone request always wins.
    always_comb begin
        pick_partner = 1'b0;
        if (bus.i_req_module && bus.i_req_partner) begin
            pick_partner = !last_partner_q;
        end else begin
            pick_partner = bus.i_req_partner;
        end
    end

    always_comb begin
        state_d         = state_q;
        msg_d           = msg_q;
        owner_partner_d = owner_partner_q;
        last_partner_d  = last_partner_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_req_module || bus.i_req_partner) begin
                    owner_partner_d = pick_partner;
                    last_partner_d  = pick_partner;
                    msg_d           = pick_partner ? bus.i_msg_partner : bus.i_msg_module;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done pulse on the terminal count still counts as success.
                if (bus.i_falling_edge_busy) begin
                    state_d = IDLE;
                end else if (cnt_q == TERM_CNT) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ERROR: begin
                if (bus.i_err_clr) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_ValidOutData = (state_q == ISSUE);
    assign bus.o_gnt_module   = (state_q == ISSUE) && !owner_partner_q;
    assign bus.o_gnt_partner  = (state_q == ISSUE) && owner_partner_q;
    assign bus.o_TX_SbMessage = ((state_q == ISSUE) || (state_q == WAIT_DONE)) ? msg_q : 4'b0000;
    assign bus.o_busy         = (state_q != IDLE);
    assign bus.o_timeout_err  = err_q;

endmodule

// File: tb/tb_mbinit_sb_tx_arbiter.sv
// Self-checking bench for mbinit_sb_tx_arbiter: directed scenarios with literal
// expectations, then random traffic against a transaction-level model.
module tb_mbinit_sb_tx_arbiter;

    localparam int T = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mbinit_sb_tx_arbiter_if bus ();

    mbinit_sb_tx_arbiter #(
        .TIMEOUT_CYCLES(T),
        .CNT_W         (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle's worth of inputs; they are sampled at the next rising edge.
    task automatic applyStimulus(input logic rm, input logic [3:0] mm, input logic rp,
                                 input logic [3:0] mp, input logic done, input logic clr,
                                 input logic r);
        rst                     = r;
        bus.i_req_module        = rm;
        bus.i_msg_module        = mm;
        bus.i_req_partner       = rp;
        bus.i_msg_partner       = mp;
        bus.i_falling_edge_busy = done;
        bus.i_err_clr           = clr;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Transaction-level model: a launch slot, an in-flight message with its wait
    // age, a sticky error, and which side was granted last.
    bit         m_live = 1'b0;
    bit         m_err, m_launch, m_inflight, m_owner_partner, m_last_partner;
    logic [3:0] m_msg;
    int         m_age;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1; m_err = 1'b0; m_launch = 1'b0; m_inflight = 1'b0;
            m_owner_partner = 1'b0; m_last_partner = 1'b0; m_msg = 4'h0; m_age = 0;
        end else if (m_live) begin
            if (m_err) begin
                if (bus.i_err_clr) m_err = 1'b0;
            end else if (m_launch) begin
                m_launch = 1'b0; m_inflight = 1'b1; m_age = 0;
            end else if (m_inflight) begin
                if (bus.i_falling_edge_busy) m_inflight = 1'b0;
                else if (m_age == T - 1) begin m_inflight = 1'b0; m_err = 1'b1; end
                else m_age++;
            end else if (bus.i_req_module || bus.i_req_partner) begin
                m_owner_partner = (bus.i_req_module && bus.i_req_partner) ? !m_last_partner
                                                                           : bus.i_req_partner;
                m_last_partner  = m_owner_partner;
                m_msg           = m_owner_partner ? bus.i_msg_partner : bus.i_msg_module;
                m_launch        = 1'b1;
            end
        end
        if (m_live) begin
            #1;
            checkOutput("model_valid", bus.o_ValidOutData, m_launch);
            checkOutput("model_gnt_module", bus.o_gnt_module, m_launch && !m_owner_partner);
            checkOutput("model_gnt_partner", bus.o_gnt_partner, m_launch && m_owner_partner);
            checkOutput("model_msg", bus.o_TX_SbMessage, (m_launch || m_inflight) ? m_msg : 4'h0);
            checkOutput("model_busy", bus.o_busy, m_launch || m_inflight || m_err);
            checkOutput("model_err", bus.o_timeout_err, m_err);
            checkOutput("gnt_onehot", bus.o_gnt_module & bus.o_gnt_partner, 4'h0);
            checkOutput("gnt_without_valid", (bus.o_gnt_module | bus.o_gnt_partner) & ~bus.o_ValidOutData, 4'h0);
        end
    end

    initial begin
        bus.i_req_module = 1'b0; bus.i_msg_module = 4'h0; bus.i_req_partner = 1'b0;
        bus.i_msg_partner = 4'h0; bus.i_falling_edge_busy = 1'b0; bus.i_err_clr = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h5, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_busy", bus.o_busy, 4'h0);
        checkOutput("reset_valid", bus.o_ValidOutData, 4'h0);
        checkOutput("reset_err", bus.o_timeout_err, 4'h0);
        checkOutput("reset_msg", bus.o_TX_SbMessage, 4'h0);

        $display("[TB] single request");
        applyStimulus(1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("single_valid", bus.o_ValidOutData, 4'h1);
        checkOutput("single_gnt_module", bus.o_gnt_module, 4'h1);
        checkOutput("single_msg", bus.o_TX_SbMessage, 4'hA);
        idleCycles(1);
        checkOutput("single_gnt_pulse", bus.o_gnt_module, 4'h0);
        checkOutput("single_msg_hold", bus.o_TX_SbMessage, 4'hA);
        idleCycles(3);
        checkOutput("single_busy_before_done", bus.o_busy, 4'h1);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("single_busy_after_done", bus.o_busy, 4'h0);
        checkOutput("single_msg_idle", bus.o_TX_SbMessage, 4'h0);

        $display("[TB] tie after reset");
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        for (int g = 0; g < 4; g++) begin
            applyStimulus(1'b1, 4'h3, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
            checkOutput("tie_gnt_partner", bus.o_gnt_partner, (g % 2 == 0) ? 4'h1 : 4'h0);
            checkOutput("tie_gnt_module", bus.o_gnt_module, (g % 2 == 1) ? 4'h1 : 4'h0);
            checkOutput("tie_msg", bus.o_TX_SbMessage, (g % 2 == 0) ? 4'h5 : 4'h3);
            applyStimulus(1'b1, 4'h3, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, 4'h3, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
        end

        $display("[TB] message stability");
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        checkOutput("stable_gnt_partner", bus.o_gnt_partner, 4'h1);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        checkOutput("stable_msg_wait", bus.o_TX_SbMessage, 4'h9);
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        checkOutput("stable_msg_wait2", bus.o_TX_SbMessage, 4'h9);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

        $display("[TB] timeout");
        applyStimulus(1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        idleCycles(T);
        checkOutput("timeout_not_yet", bus.o_timeout_err, 4'h0);
        idleCycles(1);
        checkOutput("timeout_err", bus.o_timeout_err, 4'h1);
        checkOutput("timeout_msg", bus.o_TX_SbMessage, 4'h0);
        checkOutput("timeout_busy", bus.o_busy, 4'h1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
            checkOutput("error_no_valid", bus.o_ValidOutData, 4'h0);
        end
        applyStimulus(1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
        checkOutput("clear_err", bus.o_timeout_err, 4'h0);
        checkOutput("clear_busy", bus.o_busy, 4'h0);

        $display("[TB] done at terminal count");
        applyStimulus(1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        idleCycles(T);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("terminal_err", bus.o_timeout_err, 4'h0);
        checkOutput("terminal_busy", bus.o_busy, 4'h0);

        $display("[TB] reset mid transfer");
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
        checkOutput("midreset_busy", bus.o_busy, 4'h0);
        checkOutput("midreset_msg", bus.o_TX_SbMessage, 4'h0);
        checkOutput("midreset_gnt", bus.o_gnt_partner, 4'h0);
        applyStimulus(1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        checkOutput("midreset_tie_partner", bus.o_gnt_partner, 4'h1);
        checkOutput("midreset_tie_module", bus.o_gnt_module, 4'h0);
        idleCycles(1);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 199) == 0));
        end
        idleCycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
